frac_ce_gen: RTL

Multi-channel fractional clock-enable generator for the core's `clk_sys` domain. Each channel produces single-cycle `ce` pulses at an average rate of num/den of the clock, using an exact modulo accumulator with no long-term drift, e.g. 895/36000 for a 0.895 MHz audio enable from 36 MHz. It generalises the fixed, single-channel accumulator used for audio enables. It adds per-channel runtime configuration, run gating, synchronous phase restart, invalid-ratio detection and pulse counters. It sits between the PLL clock and the core's CPU, sound and pixel enable inputs.

---
 rtl/frac_ce_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/frac_ce_gen.sv
`default_nettype none
// ============================================================================
// Module   : frac_ce_gen
// Purpose  : Multi-channel fractional clock-enable generator. Each channel
//            emits single-cycle ce pulses at an average rate of num/den of
//            clk_sys. It uses an exact modulo accumulator, so there is no
//            long-term drift. The block also provides per-channel runtime
//            ratio configuration, run gating, synchronous phase restart,
//            sticky invalid-ratio flags and wrapping pulse counters.
// Ports    : clk_sys  - single clock
//            reset    - asynchronous active-high reset
//            run      - per-channel advance enable
//            restart  - synchronous clear of all accumulators
//            cfg_wr   - one-cycle config write strobe
//            cfg_ch   - channel addressed by cfg_wr (>= CHANNELS is ignored)
//            cfg_num  - new numerator
//            cfg_den  - new denominator
//            ce       - registered enable pulses, one bit per channel
//            err      - invalid-ratio flag (num >= den or den == 0)
//            cnt      - pulse counters, channel i at [i*CNT_W +: CNT_W]
// Revision : 1.0 - initial release
// ============================================================================
module frac_ce_gen #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 16,
  parameter int CNT_W    = 8,
  parameter int DEF_NUM  = 895,
  parameter int DEF_DEN  = 36000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       run,
  input  logic                      restart,
  input  logic                      cfg_wr,
  input  logic [2:0]                cfg_ch,
  input  logic [ACC_W-1:0]          cfg_num,
  input  logic [ACC_W-1:0]          cfg_den,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS-1:0]       err,
  output logic [CHANNELS*CNT_W-1:0] cnt
);

  localparam logic [ACC_W-1:0] c_def_num = ACC_W'(DEF_NUM);
  localparam logic [ACC_W-1:0] c_def_den = ACC_W'(DEF_DEN);
  localparam logic             c_def_err = (c_def_num >= c_def_den) ||
                                           (c_def_den == '0);

  // Validity of the ratio being written, shared by every channel.
  logic w_cfg_err;
  assign w_cfg_err = (cfg_num >= cfg_den) || (cfg_den == '0);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [2:0] c_idx = 3'(gi);

    logic [ACC_W-1:0] r_num;
    logic [ACC_W-1:0] r_den;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ce;
    logic             r_err;

    logic [ACC_W:0]   w_sum;
    logic [ACC_W:0]   w_den_x;
    logic             w_cross;
    logic             w_sel;
    logic             w_invalid;

    // One extra bit keeps acc + num exact for any den < 2^ACC_W.
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_num};
    assign w_den_x   = {1'b0, r_den};
    assign w_cross   = (w_sum >= w_den_x);
    assign w_sel     = cfg_wr && (cfg_ch == c_idx);
    assign w_invalid = (r_num >= r_den) || (r_den == '0);

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        r_num <= c_def_num;
        r_den <= c_def_den;
        r_acc <= '0;
        r_cnt <= '0;
        r_ce  <= 1'b0;
        r_err <= c_def_err;
      end else if (w_sel) begin
        // A config write wins over restart for its own channel; both clear acc.
        r_num <= cfg_num;
        r_den <= cfg_den;
        r_acc <= '0;
        r_ce  <= 1'b0;
        r_err <= w_cfg_err;
      end else if (restart) begin
        r_acc <= '0;
        r_ce  <= 1'b0;
      end else if (!run[gi]) begin
        // Phase is held so resuming continues the same pulse sequence.
        r_ce  <= 1'b0;
      end else if (w_invalid) begin
        // Degenerate ratio: saturate to an enable on every running cycle.
        r_acc <= '0;
        r_ce  <= 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end else if (w_cross) begin
        // Remainder is below den, so it always fits back into ACC_W bits.
        r_acc <= ACC_W'(w_sum - w_den_x);
        r_ce  <= 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ce  <= 1'b0;
      end
    end

    assign ce[gi]                  = r_ce;
    assign err[gi]                 = r_err;
    assign cnt[gi*CNT_W +: CNT_W]  = r_cnt;
  end

endmodule
`default_nettype wire
